reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter REG_BIT, default 5, architectural register index width (32 registers).
REQ-002 Parameter ROB_BIT, default 4, ROB entry tag width (16 entries).
REQ-003 Parameter REG_NUM, default 32, number of architectural registers.
REQ-004 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 rdy_in  input  1  when low, no state changes; query outputs stay valid.
REQ-007 rename_valid  input  1  issue stage renames rename_rd to a ROB entry this cycle.
REQ-008 rename_rd  input  REG_BIT  destination register being renamed.
REQ-009 rename_entry  input  ROB_BIT  ROB tag that will produce rename_rd.
REQ-010 commit_valid  input  1  ROB commits a register-writing instruction this cycle.
REQ-011 commit_rd  input  REG_BIT  committed destination register.
REQ-012 commit_entry  input  ROB_BIT  ROB tag of the committing instruction.
REQ-013 commit_value  input  32  committed result.
REQ-014 flush_in  input  1  misprediction/jalr recovery; discard all renames.
REQ-015 rs1_id, rs2_id  input  REG_BIT each  source register queries from issue.
REQ-016 rs1_busy, rs2_busy  output  1 each  source awaits a ROB result.
REQ-017 rs1_tag, rs2_tag  output  ROB_BIT each  producing ROB entry; 0 when not busy.
REQ-018 rs1_value, rs2_value  output  32 each  architectural value; valid when not busy.
REQ-019 busy_count  output  REG_BIT+1  registered count of registers currently busy.

Function
REQ-020 Per register: value[31:0], busy, tag[ROB_BIT-1:0].
REQ-021 x0: value always 0, never busy; renames and commits targeting x0 ignored.
REQ-022 Queries combinational, zero latency; reflect state plus same-cycle commit bypass; same-cycle rename NOT visible (sources read before own destination rename).
REQ-023 Commit bypass: commit_valid, commit_rd==id, stored tag==commit_entry, no flush -> busy=0, value=commit_value.
REQ-024 Commit: value[commit_rd] <= commit_value unconditionally (non-x0); busy cleared only if tag[commit_rd]==commit_entry.
REQ-025 Commit with mismatched tag: value updated, busy/tag unchanged (younger rename pending).
REQ-026 Rename: busy[rename_rd] <= 1, tag <= rename_entry; re-rename of busy register overwrites tag.
REQ-027 Rename and commit same register same cycle: value written, rename wins busy/tag.
REQ-028 flush_in: all busy cleared, tags zeroed next edge; same-cycle commit value still written; same-cycle rename discarded.
REQ-029 busy_count updated each edge to post-update number of busy registers; range 0..REG_NUM-1.
REQ-030 rdy_in low overrides rename, commit, flush: all ignored that cycle.

Reset
REQ-031 rst_in low: all values 0, busy 0, tags 0, busy_count 0, immediately and asynchronously.
REQ-032 Reset mid-operation discards pending renames; queries read 0/not busy while rst_in low.
REQ-033 First edge after rst_in rises accepts rename/commit normally.

Structure
REQ-034 REG_BIT, ROB_BIT, REG_NUM, ROB_SIZE belong in the shared constants file.
REQ-035 Single module; one natural sub-module reg_query_port (combinational read + bypass), instantiated twice.

Verification
REQ-036 Rename x5->entry 3, query rs1=5 next cycle -> rs1_busy=1, rs1_tag=3, busy_count=1.
REQ-037 Commit x5 entry 3 value 0xDEADBEEF with rs1=5 same cycle -> rs1_busy=0, rs1_value=0xDEADBEEF; next cycle busy_count=0.
REQ-038 Rename x7->2, rename x7->6, commit x7 entry 2 value 0x11 -> x7 busy, tag 6, value 0x11.
REQ-039 Rename x1->1, x2->2, x3->3, then flush with commit x4 entry 9 value 0x22 -> all not busy, x4=0x22, busy_count=0.
REQ-040 Rename x0->4, commit x0 value 0x55 -> rs1=0 reads value 0, busy 0; rdy_in low with rename x9 -> x9 not busy.
REQ-041 Rename x10->5, assert rst_in low between edges -> outputs cleared immediately, x10 not busy.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the rename register file.
// Holds sizing defaults and the data word type.
package reg_file_pkg;

  localparam int REG_BIT  = 5;
  localparam int ROB_BIT  = 4;
  localparam int REG_NUM  = 32;
  localparam int ROB_SIZE = 16;
  localparam int XLEN     = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/reg_query_port.sv
// One combinational source-operand read port with commit bypass.
// In: id, state arrays, bypass enable, commit; out: busy/tag/value.
module reg_query_port
  import reg_file_pkg::*;
#(
  parameter int REG_BIT = reg_file_pkg::REG_BIT,
  parameter int ROB_BIT = reg_file_pkg::ROB_BIT,
  parameter int REG_NUM = reg_file_pkg::REG_NUM
) (
  input  logic [REG_BIT-1:0]              id,
  input  word_t [REG_NUM-1:0]             values,
  input  logic [REG_NUM-1:0]              busy_vec,
  input  logic [REG_NUM-1:0][ROB_BIT-1:0] tags,
  input  logic                            byp_en,
  input  logic [REG_BIT-1:0]              commit_rd,
  input  logic [ROB_BIT-1:0]              commit_entry,
  input  word_t                           commit_value,
  output logic                            q_busy,
  output logic [ROB_BIT-1:0]              q_tag,
  output word_t                           q_value
);

  logic hit;

  // A commit that retires exactly the producer this source waits on
  // resolves the source in the same cycle.
  always_comb begin
    hit = byp_en
        && (commit_rd == id)
        && (id != '0)
        && (tags[id] == commit_entry);
    q_busy  = busy_vec[id] & ~hit;
    q_tag   = q_busy ? tags[id] : '0;
    q_value = hit ? commit_value : values[id];
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename busy/tag tracking.
// Rename/commit/flush updates, two query ports, busy_count.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_BIT = reg_file_pkg::REG_BIT,
  parameter int ROB_BIT = reg_file_pkg::ROB_BIT,
  parameter int REG_NUM = reg_file_pkg::REG_NUM
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rename_valid,
  input  logic [REG_BIT-1:0] rename_rd,
  input  logic [ROB_BIT-1:0] rename_entry,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_rd,
  input  logic [ROB_BIT-1:0] commit_entry,
  input  word_t              commit_value,
  input  logic               flush_in,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [ROB_BIT-1:0] rs1_tag,
  output logic [ROB_BIT-1:0] rs2_tag,
  output word_t              rs1_value,
  output word_t              rs2_value,
  output logic [REG_BIT:0]   busy_count
);

  word_t [REG_NUM-1:0]             val_q, val_d;
  logic  [REG_NUM-1:0]             busy_q, busy_d;
  logic  [REG_NUM-1:0][ROB_BIT-1:0] tag_q, tag_d;
  logic  [REG_BIT:0]               cnt_d;
  logic                            byp_en;

  // Bypass only for a commit that will really take effect,
  // and never while reset holds the file cleared.
  assign byp_en = rst_in & rdy_in & commit_valid & ~flush_in;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (commit_valid && commit_rd != '0) begin
        val_d[commit_rd] = commit_value;
        if (tag_q[commit_rd] == commit_entry) begin
          busy_d[commit_rd] = 1'b0;
          tag_d[commit_rd]  = '0;
        end
      end
      // Rename is applied after commit so it wins busy/tag.
      if (flush_in) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (rename_valid && rename_rd != '0) begin
        busy_d[rename_rd] = 1'b1;
        tag_d[rename_rd]  = rename_entry;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d = cnt_d + (REG_BIT+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      val_q      <= '0;
      busy_q     <= '0;
      tag_q      <= '0;
      busy_count <= '0;
    end else if (rdy_in) begin
      val_q      <= val_d;
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      busy_count <= cnt_d;
    end
  end

  reg_query_port #(
    .REG_BIT(REG_BIT),
    .ROB_BIT(ROB_BIT),
    .REG_NUM(REG_NUM)
  ) u_rs1 (
    .id          (rs1_id),
    .values      (val_q),
    .busy_vec    (busy_q),
    .tags        (tag_q),
    .byp_en      (byp_en),
    .commit_rd   (commit_rd),
    .commit_entry(commit_entry),
    .commit_value(commit_value),
    .q_busy      (rs1_busy),
    .q_tag       (rs1_tag),
    .q_value     (rs1_value)
  );

  reg_query_port #(
    .REG_BIT(REG_BIT),
    .ROB_BIT(ROB_BIT),
    .REG_NUM(REG_NUM)
  ) u_rs2 (
    .id          (rs2_id),
    .values      (val_q),
    .busy_vec    (busy_q),
    .tags        (tag_q),
    .byp_en      (byp_en),
    .commit_rd   (commit_rd),
    .commit_entry(commit_entry),
    .commit_value(commit_value),
    .q_busy      (rs2_busy),
    .q_tag       (rs2_tag),
    .q_value     (rs2_value)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file.
// Outputs are checked 1ns after the falling edge, before the next rise.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rename_valid;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_entry;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_entry;
  logic [31:0] commit_value;
  logic        flush_in;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_value, rs2_value;
  logic [5:0]  busy_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rename_valid(rename_valid),
    .rename_rd   (rename_rd),
    .rename_entry(rename_entry),
    .commit_valid(commit_valid),
    .commit_rd   (commit_rd),
    .commit_entry(commit_entry),
    .commit_value(commit_value),
    .flush_in    (flush_in),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rs1_tag     (rs1_tag),
    .rs2_tag     (rs2_tag),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
    .busy_count  (busy_count)
  );

  typedef struct {
    logic        rv;
    logic [4:0]  rrd;
    logic [3:0]  re;
    logic        cv;
    logic [4:0]  crd;
    logic [3:0]  ce;
    logic [31:0] cval;
    logic        fl;
    logic        rdy;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] v2;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vec[20];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask

  task automatic idle();
    rename_valid = 0; rename_rd = 0; rename_entry = 0;
    commit_valid = 0; commit_rd = 0; commit_entry = 0;
    commit_value = 0; flush_in = 0; rdy_in = 1;
  endtask

  task automatic chk_q(input string p,
                       input logic b1, input logic [3:0] t1,
                       input logic [31:0] v1,
                       input logic b2, input logic [3:0] t2,
                       input logic [31:0] v2,
                       input logic [5:0] cnt);
    chk({p, " rs1_busy"}, 32'(rs1_busy), 32'(b1));
    chk({p, " rs1_tag"}, 32'(rs1_tag), 32'(t1));
    chk({p, " rs1_value"}, rs1_value, v1);
    chk({p, " rs2_busy"}, 32'(rs2_busy), 32'(b2));
    chk({p, " rs2_tag"}, 32'(rs2_tag), 32'(t2));
    chk({p, " rs2_value"}, rs2_value, v2);
    chk({p, " busy_count"}, 32'(busy_count), 32'(cnt));
  endtask

  initial begin
    // rv rrd re cv crd ce cval fl rdy s1 s2 |
    //   b1 t1 v1 b2 t2 v2 cnt
    vec[0]  = '{1,5,3, 0,0,0,0, 0,1, 5,0,
                0,0,0, 0,0,0, 0};
    vec[1]  = '{0,0,0, 0,0,0,0, 0,1, 5,7,
                1,3,0, 0,0,0, 1};
    vec[2]  = '{0,0,0, 1,5,3,32'hDEADBEEF, 0,1, 5,0,
                0,0,32'hDEADBEEF, 0,0,0, 1};
    vec[3]  = '{0,0,0, 0,0,0,0, 0,1, 5,0,
                0,0,32'hDEADBEEF, 0,0,0, 0};
    vec[4]  = '{1,7,2, 0,0,0,0, 0,1, 7,0,
                0,0,0, 0,0,0, 0};
    vec[5]  = '{1,7,6, 0,0,0,0, 0,1, 7,0,
                1,2,0, 0,0,0, 1};
    vec[6]  = '{0,0,0, 1,7,2,32'h11, 0,1, 7,0,
                1,6,0, 0,0,0, 1};
    vec[7]  = '{0,0,0, 0,0,0,0, 0,1, 7,5,
                1,6,32'h11, 0,0,32'hDEADBEEF, 1};
    vec[8]  = '{1,1,1, 0,0,0,0, 0,1, 1,0,
                0,0,0, 0,0,0, 1};
    vec[9]  = '{1,2,2, 0,0,0,0, 0,1, 1,2,
                1,1,0, 0,0,0, 2};
    vec[10] = '{1,3,3, 0,0,0,0, 0,1, 2,3,
                1,2,0, 0,0,0, 3};
    vec[11] = '{0,0,0, 1,4,9,32'h22, 1,1, 3,4,
                1,3,0, 0,0,0, 4};
    vec[12] = '{0,0,0, 0,0,0,0, 0,1, 7,4,
                0,0,32'h11, 0,0,32'h22, 0};
    vec[13] = '{1,0,4, 1,0,0,32'h55, 0,1, 0,0,
                0,0,0, 0,0,0, 0};
    vec[14] = '{1,9,1, 0,0,0,0, 0,0, 0,9,
                0,0,0, 0,0,0, 0};
    vec[15] = '{0,0,0, 0,0,0,0, 0,1, 9,0,
                0,0,0, 0,0,0, 0};
    vec[16] = '{1,9,7, 1,9,0,32'h77, 0,1, 9,0,
                0,0,32'h77, 0,0,0, 0};
    vec[17] = '{0,0,0, 0,0,0,0, 0,1, 9,0,
                1,7,32'h77, 0,0,0, 1};
    vec[18] = '{0,0,0, 1,9,7,32'hABCD, 0,1, 9,9,
                0,0,32'hABCD, 0,0,32'hABCD, 1};
    vec[19] = '{0,0,0, 0,0,0,0, 0,1, 9,3,
                0,0,32'hABCD, 0,0,0, 0};

    idle();
    rst_in = 0;
    rs1_id = 5; rs2_id = 7;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    #1 chk_q("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_in = 1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      rename_valid = vec[i].rv;
      rename_rd    = vec[i].rrd;
      rename_entry = vec[i].re;
      commit_valid = vec[i].cv;
      commit_rd    = vec[i].crd;
      commit_entry = vec[i].ce;
      commit_value = vec[i].cval;
      flush_in     = vec[i].fl;
      rdy_in       = vec[i].rdy;
      rs1_id       = vec[i].s1;
      rs2_id       = vec[i].s2;
      #1 chk_q($sformatf("v%0d", i),
               vec[i].b1, vec[i].t1, vec[i].v1,
               vec[i].b2, vec[i].t2, vec[i].v2,
               vec[i].cnt);
    end

    // rename x10 then reset asynchronously mid-cycle
    @(negedge clk_in);
    idle();
    rename_valid = 1; rename_rd = 10; rename_entry = 5;
    @(negedge clk_in);
    idle();
    rs1_id = 10; rs2_id = 9;
    #1 chk_q("pre_rst", 1, 5, 0, 0, 0, 32'hABCD, 1);
    #2 rst_in = 0;
    #1 chk_q("in_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    rst_in = 1;
    rename_valid = 1; rename_rd = 11; rename_entry = 2;
    rs1_id = 10; rs2_id = 11;
    #1 chk_q("post_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    idle();
    #1 chk_q("first_edge", 0, 0, 0, 1, 2, 0, 1);

    // flush ignored while rdy_in low
    @(negedge clk_in);
    rdy_in = 0; flush_in = 1;
    @(negedge clk_in);
    idle();
    #1 chk_q("rdy_flush", 0, 0, 0, 1, 2, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
